// File: rtl/thread_issue_scheduler_pkg.sv
// rtl/thread_issue_scheduler_pkg.sv - shared constants and FSM state type for the thread issue scheduler
package thread_issue_pkg;

  localparam int NUM_THREADS = 64;
  localparam int TID_W       = 6;
  localparam int CNT_W       = TID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/thread_issue_scheduler_if.sv
// rtl/thread_issue_scheduler_if.sv - mask-in / tid-out handshake bundle between front-end, scheduler and lane issue
interface thread_issue_scheduler_if;
  import thread_issue_pkg::*;

  logic                   mask_valid;
  logic                   mask_ready;
  logic [NUM_THREADS-1:0] mask_in;
  logic [TID_W-1:0]       start_in;
  logic                   flush;
  logic                   tid_valid;
  logic                   tid_ready;
  logic [TID_W-1:0]       tid;
  logic                   tid_last;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       done_count;

  modport master (
    output mask_valid, mask_in, start_in, flush, tid_ready,
    input  mask_ready, tid_valid, tid, tid_last, busy, done, done_count
  );

  modport slave (
    input  mask_valid, mask_in, start_in, flush, tid_ready,
    output mask_ready, tid_valid, tid, tid_last, busy, done, done_count
  );

endinterface

// File: rtl/thread_issue_scheduler_penc.sv
// rtl/thread_issue_scheduler_penc.sv - 64-bit priority encoder returning the lowest set bit at or above a start position
module priority_encoder_64bit
  import thread_issue_pkg::*;
(
  input  logic [NUM_THREADS-1:0] i_vec,
  input  logic [TID_W-1:0]       i_start,
  output logic                   o_valid,
  output logic [TID_W-1:0]       o_pos
);

  logic [NUM_THREADS-1:0] w_masked;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    w_masked = i_vec & ({NUM_THREADS{1'b1}} << i_start);
    o_valid  = |w_masked;
    o_pos    = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (w_masked[i]) o_pos = TID_W'(i);
    end
  end

endmodule

// File: rtl/thread_issue_scheduler.sv
// rtl/thread_issue_scheduler.sv - issues thread IDs from an active mask, one per cycle, rotating from a start position
module thread_issue_scheduler
  import thread_issue_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  thread_issue_scheduler_if.slave  io_bus
);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [NUM_THREADS-1:0] r_pending;
  logic [TID_W-1:0]       r_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_done_count;

  logic                   w_a_valid;
  logic [TID_W-1:0]       w_a_pos;
  logic                   w_b_valid;
  logic [TID_W-1:0]       w_b_pos;
  logic                   w_issue;
  logic [TID_W-1:0]       w_tid;
  logic [NUM_THREADS-1:0] w_rest;
  logic                   w_last;
  logic                   w_fire;

  // Search A covers ptr..63, search B supplies the wrap-around 0..ptr-1.
  priority_encoder_64bit u_search_a (
    .i_vec   (r_pending),
    .i_start (r_ptr),
    .o_valid (w_a_valid),
    .o_pos   (w_a_pos)
  );

  priority_encoder_64bit u_search_b (
    .i_vec   (r_pending),
    .i_start ('0),
    .o_valid (w_b_valid),
    .o_pos   (w_b_pos)
  );

  assign w_issue = (r_state == S_ISSUE);
  assign w_tid   = w_issue ? (w_a_valid ? w_a_pos : w_b_pos) : '0;
  assign w_rest  = r_pending & ~(NUM_THREADS'(1) << w_tid);
  assign w_last  = w_issue && (w_rest == '0);
  assign w_fire  = w_issue && w_b_valid && io_bus.tid_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.mask_valid) begin
          w_next_state = (io_bus.mask_in != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (w_fire && w_last) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (io_bus.flush) w_next_state = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_done_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (io_bus.flush) begin
        r_pending <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io_bus.mask_valid) begin
              r_pending <= io_bus.mask_in;
              r_ptr     <= io_bus.start_in;
              r_cnt     <= '0;
              if (io_bus.mask_in == '0) r_done_count <= '0;
            end
          end
          S_ISSUE: begin
            if (w_fire) begin
              r_pending <= w_rest;
              r_ptr     <= w_tid + TID_W'(1);
              r_cnt     <= r_cnt + CNT_W'(1);
              if (w_last) r_done_count <= r_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.mask_ready = (r_state == S_IDLE);
  assign io_bus.tid_valid  = w_issue && w_b_valid;
  assign io_bus.tid        = w_tid;
  assign io_bus.tid_last   = w_last;
  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.done       = (r_state == S_DONE);
  assign io_bus.done_count = r_done_count;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// tb/tb_thread_issue_scheduler.sv - randomized scoreboard bench for the thread issue scheduler
module tb_thread_issue_scheduler;
  import thread_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  thread_issue_scheduler_if bus ();

  thread_issue_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_hs = 0;
  int n_done = 0;
  int rdy_mode = 0;
  int exp_tid[$];
  bit exp_last[$];
  int exp_cnt[$];
  int exp_cyc[$];
  int mon_c;
  bit prev_stall = 1'b0;
  bit prev_done = 1'b0;
  int prev_tid;
  bit prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.tid_ready = 1'b1;
      1: bus.tid_ready = ~bus.tid_ready;
      default: bus.tid_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall && bus.tid_valid) begin
        check("stall_tid", bus.tid, prev_tid);
        check("stall_last", bus.tid_last, prev_last);
      end
      if (prev_done) check("ready_after_done", bus.mask_ready, 1);
      if (bus.tid_valid && bus.tid_ready && !bus.flush) begin
        n_hs++;
        if (exp_tid.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tid: got %0d expected none", bus.tid);
        end else begin
          check("tid", bus.tid, exp_tid.pop_front());
          check("tid_last", bus.tid_last, exp_last.pop_front());
        end
      end
      if (bus.done) begin
        n_done++;
        check("mask_ready_in_done", bus.mask_ready, 0);
        if (exp_cnt.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done_count %0d expected no done", bus.done_count);
        end else begin
          check("done_count", bus.done_count, exp_cnt.pop_front());
          mon_c = exp_cyc.pop_front();
          if (mon_c >= 0) check("done_cycle", cyc, mon_c);
        end
      end
      prev_stall = bus.tid_valid && !bus.tid_ready && !bus.flush;
      prev_tid   = bus.tid;
      prev_last  = bus.tid_last;
      prev_done  = bus.done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  // Reference order: walk start, start+1, ... modulo 64 and keep the set positions.
  task automatic start_mask(input logic [63:0] m, input int s, input bit expect_done, output int e);
    int t;
    int k;
    int q[$];
    t = 0;
    k = 0;
    while (bus.mask_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("mask_ready_timeout", 0, 1);
    for (int i = 0; i < 64; i++) begin
      int p;
      p = (s + i) % 64;
      if (m[p]) begin
        q.push_back(p);
        k++;
      end
    end
    for (int i = 0; i < k; i++) begin
      exp_tid.push_back(q[i]);
      exp_last.push_back(i == k - 1);
    end
    bus.mask_in    = m;
    bus.start_in   = 6'(s);
    bus.mask_valid = 1'b1;
    @(posedge clk); #1;
    bus.mask_valid = 1'b0;
    e = cyc;
    if (expect_done) begin
      exp_cnt.push_back(k);
      exp_cyc.push_back(rdy_mode == 0 ? e + k : -1);
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done <= target && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    while (n_hs < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("handshake_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_mask_ready", bus.mask_ready, 1);
    check("rst_tid_valid", bus.tid_valid, 0);
    check("rst_tid", bus.tid, 0);
    check("rst_tid_last", bus.tid_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_done_count", bus.done_count, 0);
  endtask

  task automatic run_mask(input logic [63:0] m, input int s, input int mode);
    int e;
    int d0;
    rdy_mode = mode;
    d0 = n_done;
    start_mask(m, s, 1'b1, e);
    wait_done(d0);
  endtask

  initial begin
    int e;
    int d0;
    int h0;
    logic [63:0] rm;
    rst_n          = 1'b0;
    bus.mask_valid = 1'b0;
    bus.mask_in    = '0;
    bus.start_in   = '0;
    bus.flush      = 1'b0;
    bus.tid_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_mask(64'h0000_0000_0000_00A5, 0, 0);
    run_mask(64'h8000_0000_0000_0003, 62, 0);
    run_mask({64{1'b1}}, 5, 1);
    run_mask(64'h0, 0, 0);
    run_mask(64'h0000_0000_0000_0040, 63, 0);

    // Flush after the third handshake while a tid is still offered.
    rdy_mode = 0;
    d0 = n_done;
    h0 = n_hs;
    start_mask(64'hFF, 0, 1'b0, e);
    wait_hs(h0 + 3);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    exp_tid.delete();
    exp_last.delete();
    check("flush_busy", bus.busy, 0);
    check("flush_tid_valid", bus.tid_valid, 0);
    check("flush_mask_ready", bus.mask_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_done", n_done, d0);
    run_mask(64'h1, 0, 0);

    // Flush together with mask_valid must not accept the mask.
    h0 = n_hs;
    bus.mask_in    = 64'h5;
    bus.start_in   = '0;
    bus.mask_valid = 1'b1;
    bus.flush      = 1'b1;
    @(posedge clk); #1;
    bus.mask_valid = 1'b0;
    bus.flush      = 1'b0;
    check("flush_mv_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("flush_mv_no_tid", n_hs, h0);

    // Reset mid-issue abandons the mask.
    h0 = n_hs;
    start_mask(64'hFFFF, 0, 1'b0, e);
    wait_hs(h0 + 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_tid.delete();
    exp_last.delete();
    check_reset_outputs();
    rst_n = 1'b1;
    run_mask(64'h10, 4, 0);

    for (int i = 0; i < 20; i++) begin
      rm = {$urandom, $urandom};
      if (i % 3 == 0) rm = rm & {$urandom, $urandom} & {$urandom, $urandom};
      run_mask(rm, $urandom_range(0, 63), $urandom_range(0, 2));
    end

    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    check("queues_drained", exp_tid.size() + exp_cnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
